// File: rtl/router_output_arbiter.sv
// Switch allocator for one router output channel.
// Round-robin with wormhole lock and credit-based flow control.
module router_output_arbiter #(
   parameter int NUM_INPUTS = 2,
   parameter int CREDITS    = 4,
   parameter int SEL_W      = $clog2(NUM_INPUTS),
   parameter int CRED_W     = $clog2(CREDITS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:NUM_INPUTS-1] req_ip,
   input  logic [0:NUM_INPUTS-1] head_ip,
   input  logic [0:NUM_INPUTS-1] tail_ip,
   input  logic                  credit_in,
   output logic [0:NUM_INPUTS-1] gnt_ip,
   output logic                  valid_op,
   output logic [SEL_W-1:0]      sel_op,
   output logic [CRED_W-1:0]     credit_cnt,
   output logic                  locked,
   output logic                  error
);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SEL_W-1:0]      r_owner;
   logic [SEL_W-1:0]      r_last;
   logic [SEL_W-1:0]      r_sel;
   logic [CRED_W-1:0]     r_cred;
   logic                  r_err;

   logic [0:NUM_INPUTS-1] w_cand;
   logic                  w_hit;
   logic [SEL_W-1:0]      w_win;
   logic [SEL_W-1:0]      w_gnt_idx;
   logic                  w_gnt_tail;
   logic                  w_gnt_head;
   logic                  w_over;
   logic                  w_bad_head;
   logic [CRED_W-1:0]     w_cred_nxt;

   // Round-robin scan of head requests, starting just after the last winner
   always_comb begin
      int v_idx;
      w_cand = req_ip & head_ip;
      w_hit  = 1'b0;
      w_win  = '0;
      v_idx  = 0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         v_idx = (int'(r_last) + k) % NUM_INPUTS;
         if (!w_hit && w_cand[v_idx]) begin
            w_hit = 1'b1;
            w_win = SEL_W'(v_idx);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: a non-tail grant locks, a tail grant releases
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (valid_op && !w_gnt_tail) w_state_nxt = S_LOCKED;
         S_LOCKED: if (valid_op && w_gnt_tail)  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: zero-latency grant, gated by reset and credits
   always_comb begin
      gnt_ip = '0;
      if (reset && (r_cred != '0)) begin
         case (r_state)
            S_IDLE:   if (w_hit) gnt_ip[w_win] = 1'b1;
            S_LOCKED: if (req_ip[r_owner]) gnt_ip[r_owner] = 1'b1;
            default:  gnt_ip = '0;
         endcase
      end
      valid_op  = |gnt_ip;
      locked    = (r_state == S_LOCKED);
      w_gnt_idx = locked ? r_owner : w_win;
   end

   // Credit bookkeeping and protocol error detection
   always_comb begin
      w_gnt_tail = |(gnt_ip & tail_ip);
      w_gnt_head = |(gnt_ip & head_ip);
      w_over     = credit_in && !valid_op &&
                   (r_cred == CRED_W'(CREDITS));
      w_bad_head = locked && w_gnt_head;
      if (w_over) w_cred_nxt = r_cred;
      else        w_cred_nxt = r_cred + CRED_W'(credit_in)
                                      - CRED_W'(valid_op);
   end

   // Owner, round-robin pointer, mux select, credits and sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner <= '0;
         r_last  <= SEL_W'(NUM_INPUTS - 1);
         r_sel   <= '0;
         r_cred  <= CRED_W'(CREDITS);
         r_err   <= 1'b0;
      end else begin
         r_cred <= w_cred_nxt;
         if (w_over || w_bad_head) r_err <= 1'b1;
         if (valid_op) begin
            r_sel <= w_gnt_idx;
            if (w_gnt_tail) r_last  <= w_gnt_idx;
            else            r_owner <= w_gnt_idx;
         end
      end
   end

   assign sel_op     = r_sel;
   assign credit_cnt = r_cred;
   assign error      = r_err;

endmodule
